// File: rtl/beat_pkg.sv
// Shared defaults, FSM states and offset successor
// for the beat data receiver.
package beat_pkg;

  localparam int unsigned STEP_DEF = 4;
  localparam int unsigned WRAP_DEF = 16;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } beat_state_e;

  // Callers truncate the result to their sample width.
  function automatic logic [31:0] beat_next(
    input logic [31:0] x,
    input logic [31:0] step,
    input logic [31:0] wrap
  );
    return (x == wrap) ? 32'd0 : x + step;
  endfunction

endpackage

// File: rtl/beat_fifo.sv
// Show-ahead FIFO; a push into a full FIFO succeeds
// when a pop happens in the same cycle.
module beat_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Gate the head so stale storage never shows after reset.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/beat_data_receiver.sv
// Locks onto the beat-offset stream, checks each sample
// and buffers accepted offsets for the note spawner.
module beat_data_receiver
  import beat_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned STEP   = STEP_DEF,
  parameter int unsigned WRAP   = WRAP_DEF,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_en,
  input  logic [DATA_W-1:0] data,
  input  logic              out_ready,
  input  logic              clr_flags,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              locked,
  output logic              overflow,
  output logic              seq_err,
  output logic [7:0]        err_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  beat_state_e       state;
  beat_state_e       state_nxt;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] expected_nxt;
  logic [DATA_W-1:0] succ;
  logic              accept;
  logic              mism;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     unused_count;

  assign succ = DATA_W'(beat_next(32'(data), STEP, WRAP));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // A mismatching 0 only returns to HUNT; it is not a lock point.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mism      = 1'b0;
    unique case (state)
      HUNT: begin
        if (data_en && data == '0) begin
          accept    = 1'b1;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (data_en) begin
          if (data == expected) begin
            accept = 1'b1;
          end else begin
            mism      = 1'b1;
            state_nxt = HUNT;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_comb begin
    expected_nxt = expected;
    if (accept) begin
      expected_nxt = succ;
    end else if (mism) begin
      expected_nxt = '0;
    end
  end

  assign pop  = out_valid && out_ready;
  assign drop = accept && fifo_full && !pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      expected  <= '0;
      overflow  <= 1'b0;
      seq_err   <= 1'b0;
      err_count <= '0;
    end else begin
      expected <= expected_nxt;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end
      // A fresh error beats a same-cycle clear.
      if (mism) begin
        seq_err <= 1'b1;
        if (clr_flags) begin
          err_count <= 8'd1;
        end else if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end else if (clr_flags) begin
        seq_err   <= 1'b0;
        err_count <= '0;
      end
    end
  end

  beat_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept),
    .push_data(data),
    .pop      (pop),
    .head     (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (unused_count)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_beat_data_receiver.sv
// Directed bench for beat_data_receiver: lock, resync,
// overflow, full push+pop, saturation and async reset.
module tb_beat_data_receiver;

  logic       clk = 1'b0;
  logic       resetn;
  logic       data_en;
  logic [7:0] data;
  logic       out_ready;
  logic       clr_flags;
  logic       out_valid;
  logic [7:0] out_data;
  logic       locked;
  logic       overflow;
  logic       seq_err;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;

  beat_data_receiver dut (
    .clk      (clk),
    .resetn   (resetn),
    .data_en  (data_en),
    .data     (data),
    .out_ready(out_ready),
    .clr_flags(clr_flags),
    .out_valid(out_valid),
    .out_data (out_data),
    .locked   (locked),
    .overflow (overflow),
    .seq_err  (seq_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic [7:0] d,
                      input logic rdy, input logic clr);
    data_en   = en;
    data      = d;
    out_ready = rdy;
    clr_flags = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    data_en   = 1'b0;
    data      = '0;
    out_ready = 1'b0;
    clr_flags = 1'b0;
    resetn    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  logic [7:0] s1 [7] = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd16, 8'd0, 8'd4};
  logic [7:0] s4 [10] = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd16,
                          8'd0, 8'd4, 8'd8, 8'd12, 8'd16};
  logic [7:0] s5 [7] = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd0, 8'd4, 8'd8};

  initial begin
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", seq_err, 0);
    chk("rst_cnt", err_count, 0);

    // clean stream, output one cycle late
    for (int i = 0; i < 7; i++) begin
      step(1, s1[i], 1, 0);
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, s1[i]);
      chk("t1_locked", locked, 1);
    end
    step(0, 0, 1, 0);
    chk("t1_drained", out_valid, 0);
    chk("t1_err", seq_err, 0);
    chk("t1_ovf", overflow, 0);

    // hunting discards 8,12,16
    do_reset();
    step(1, 8, 1, 0);
    chk("t2_8_valid", out_valid, 0);
    chk("t2_8_lock", locked, 0);
    step(1, 12, 1, 0);
    chk("t2_12_valid", out_valid, 0);
    step(1, 16, 1, 0);
    chk("t2_16_valid", out_valid, 0);
    chk("t2_16_lock", locked, 0);
    step(1, 0, 1, 0);
    chk("t2_0_lock", locked, 1);
    chk("t2_0_data", out_data, 0);
    step(1, 4, 1, 0);
    chk("t2_4_data", out_data, 4);
    chk("t2_err", seq_err, 0);
    chk("t2_cnt", err_count, 0);

    // mismatch while locked
    do_reset();
    step(1, 0, 1, 0);
    step(1, 4, 1, 0);
    step(1, 12, 1, 0);
    chk("t3_lock", locked, 0);
    chk("t3_err", seq_err, 1);
    chk("t3_cnt", err_count, 1);
    chk("t3_valid", out_valid, 0);
    step(1, 0, 1, 0);
    chk("t3_relock", locked, 1);
    chk("t3_relock_data", out_data, 0);
    step(1, 0, 1, 0);
    chk("t3_bad0_lock", locked, 0);
    chk("t3_bad0_cnt", err_count, 2);
    chk("t3_bad0_valid", out_valid, 0);
    step(1, 0, 1, 0);
    chk("t3_relock2", locked, 1);
    step(0, 0, 1, 1);
    chk("t3_clr_err", seq_err, 0);
    chk("t3_clr_cnt", err_count, 0);

    // overflow with out_ready low
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, s4[i], 0, 0);
      chk("t4_head", out_data, 0);
      chk("t4_ovf", overflow, (i >= 8) ? 1 : 0);
    end
    chk("t4_locked", locked, 1);
    chk("t4_err", seq_err, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain_valid", out_valid, 1);
      chk("t4_drain_data", out_data, s4[i]);
      step(0, 0, 1, 0);
    end
    chk("t4_empty", out_valid, 0);
    step(1, 0, 0, 0);
    chk("t4_next_err", seq_err, 0);
    chk("t4_next_data", out_data, 0);
    chk("t4_next_lock", locked, 1);

    // fill to 8, then push+pop while full
    for (int i = 0; i < 7; i++) begin
      step(1, s5[i], 0, 0);
    end
    step(0, 0, 0, 1);
    chk("t5_clr_ovf", overflow, 0);
    step(1, 12, 1, 0);
    chk("t5_pp_ovf", overflow, 0);
    chk("t5_pp_data", out_data, 4);
    step(1, 16, 0, 0);
    chk("t5_full_ovf", overflow, 1);
    chk("t5_full_lock", locked, 1);

    // 300 mismatches, then clear colliding with an error
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 1, 0);
      step(1, 8, 1, 0);
    end
    chk("t6_sat", err_count, 255);
    chk("t6_err", seq_err, 1);
    chk("t6_lock", locked, 0);
    step(1, 0, 1, 0);
    step(1, 8, 1, 1);
    chk("t6_clr_cnt", err_count, 1);
    chk("t6_clr_err", seq_err, 1);
    chk("t6_clr_ovf", overflow, 0);

    // asynchronous reset mid-stream
    step(1, 0, 1, 0);
    chk("t7_pre_valid", out_valid, 1);
    chk("t7_pre_lock", locked, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t7_valid", out_valid, 0);
    chk("t7_data", out_data, 0);
    chk("t7_lock", locked, 0);
    chk("t7_ovf", overflow, 0);
    chk("t7_err", seq_err, 0);
    chk("t7_cnt", err_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beat_data_receiver.md
# beat_data_receiver

Consumer end of the beatmap data stream. Samples the `data_en`/`data` beat-offset stream (0, 4, 8, 12, 16, 0, …), locks onto its sequence, checks every sample against the expected step, and buffers accepted offsets in a small FIFO. Offsets are presented to the downstream note spawner through a valid/ready interface. The stream source has no backpressure, so this block absorbs, drops and flags.

## Interface
- `DATA_W`, 8: width of beat-offset samples.
- `STEP`, 4: increment between consecutive offsets.
- `WRAP`, 16: last offset before the sequence returns to 0.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; all logic on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `data_en`  in  1  sample qualifier from the stream source.
- `data`  in  DATA_W  beat offset; valid when `data_en`=1.
- `out_ready`  in  1  downstream accepts the head entry.
- `clr_flags`  in  1  one-cycle pulse; clears the sticky flags and the error count.
- `out_valid`  out  1  FIFO non-empty.
- `out_data`  out  DATA_W  FIFO head (show-ahead).
- `locked`  out  1  FSM is in LOCKED.
- `overflow`  out  1  sticky: an accepted sample was dropped because the FIFO was full.
- `seq_err`  out  1  sticky: sequence mismatch seen.
- `err_count`  out  8  saturating count of mismatches (stops at 255).

## Operation
- A sample is any cycle with `data_en`=1. Cycles with `data_en`=0 are ignored in every state; gaps are legal.
- Successor function: next(x) = 0 if x==WRAP, else x+STEP. Computed at DATA_W bits; no carry is kept.
- FSM has two states, reset to HUNT.
  - HUNT: a sample with `data`==0 is accepted (pushed), sets expected=next(0), and moves to LOCKED. Any other sample is discarded silently; no error is flagged.
  - LOCKED, sample == expected: accept (push) and set expected=next(expected).
  - LOCKED, sample ≠ expected: drop the sample, set `seq_err`, increment `err_count` (saturating), go to HUNT. A mismatching 0 is not re-used as a lock point in the same cycle.
- Push rule: push succeeds if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle. Otherwise the sample is dropped and `overflow` is set. Sequence tracking advances regardless of the drop.
- Pop occurs when `out_valid` && `out_ready`.
- `clr_flags` clears `overflow`, `seq_err` and `err_count`. If a new error occurs in the same cycle, the new error wins: the flag is set and `err_count`=1.
- Reset values: state HUNT, expected 0, FIFO empty, all outputs 0.
- Asserting reset mid-stream discards the FIFO contents and the lock immediately.

## Timing
- Sample at edge N with an empty FIFO → `out_valid`=1 and `out_data`=sample after edge N (latency 1).
- `locked`, `seq_err`, `overflow` and `err_count` update at the same edge as the triggering sample.
- Pop at edge N → next entry visible after edge N; `out_valid` falls after edge N if that was the last entry.
- Simultaneous push and pop on an empty FIFO cannot occur (`out_valid`=0). On a non-empty FIFO, count is unchanged.
- Sustained throughput is 1 sample/cycle in and 1 entry/cycle out.

## Structure
- Package `beat_pkg` holds the `STEP`/`WRAP` defaults, the state enum (HUNT, LOCKED) and the successor function.
- Sub-module `beat_fifo`: synchronous show-ahead FIFO (DEPTH, DATA_W) with push/pop/full/empty/count, including same-cycle push-and-pop-when-full support.
- FSM, checker and sticky flags live in the top level.

## Test plan
- Reset release, stream 0,4,8,12,16,0,4 with `out_ready`=1 → `out_data` follows the stream one cycle late; `locked`=1 from the first 0; no flags set.
- Stream starting at 8,12,16,0,4 → 8, 12 and 16 are discarded, lock occurs at 0, outputs are 0 then 4, `seq_err`=0.
- While locked, inject 0,4,12 → 12 is dropped, `seq_err`=1, `err_count`=1, `locked`=0. The next 0 relocks.
- `out_ready`=0 for 10 samples (DEPTH=8) → first 8 stored; the 9th and 10th are dropped; `overflow`=1; the next sample expected is still correct. Draining yields 0,4,8,12,16,0,4,8.
- FIFO full, push and pop in the same cycle → count stays 8 and no overflow.
- 300 mismatches, then a `clr_flags` pulse coinciding with a new mismatch → `err_count` saturates at 255, then reads 1 with `seq_err`=1. Reset asserted mid-stream → all outputs 0 asynchronously.
